// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand-fetch slice.
// Register-id sizing and the hard-wired zero register.
package operand_fetch_pkg;

  function automatic int id_bits(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int REG_ZERO   = 0;
  localparam int OP_BIT_DEF = 4;
  localparam int REG_ID_BIT = id_bits(8);

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Destination scoreboard: busy bits, hazard lookup and
// sticky error on writeback to an idle register.
module reg_scoreboard
  import operand_fetch_pkg::*;
#(
  parameter int NUM_REG    = 8,
  parameter int NUM_W_PORT = 2,
  parameter int RID        = id_bits(NUM_REG)
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_set_vld,
  input  logic [RID-1:0]            i_set_addr,
  input  logic [NUM_W_PORT-1:0]     i_wb_vld,
  input  logic [NUM_W_PORT*RID-1:0] i_wb_addr,
  input  logic [RID-1:0]            i_chk0,
  input  logic [RID-1:0]            i_chk1,
  input  logic [RID-1:0]            i_chk2,
  input  logic                      i_chk2_vld,
  output logic                      o_hazard,
  output logic                      o_any_busy,
  output logic                      o_sb_err
);

  localparam logic [RID-1:0] Z = RID'(REG_ZERO);

  logic [NUM_REG-1:0] r_busy;
  logic [NUM_REG-1:0] w_set;
  logic [NUM_REG-1:0] w_clr;
  logic [RID-1:0]     w_a;
  logic               w_err;
  logic               r_err;

  always_comb begin
    w_clr = '0;
    w_err = 1'b0;
    w_a   = '0;
    for (int j = 0; j < NUM_W_PORT; j++) begin
      w_a = i_wb_addr[j*RID +: RID];
      if (i_wb_vld[j] && w_a != Z) begin
        w_clr[w_a] = 1'b1;
        if (!r_busy[w_a]) w_err = 1'b1;
      end
    end
  end

  always_comb begin
    w_set = '0;
    if (i_set_vld && i_set_addr != Z)
      w_set[i_set_addr] = 1'b1;
  end

  // set applied after clear so a same-cycle set wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
      r_err  <= r_err | w_err;
    end
  end

  assign o_hazard =
      (i_chk0 != Z && r_busy[i_chk0])
    | (i_chk1 != Z && r_busy[i_chk1])
    | (i_chk2_vld && i_chk2 != Z && r_busy[i_chk2]);

  assign o_any_busy = |r_busy;
  assign o_sb_err   = r_err;

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: hazard-gated issue to one register-file
// read port, sideband tracking and execute output register.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int NUM_REG    = 8,
  parameter int REG_BIT    = 16,
  parameter int NUM_W_PORT = 2,
  parameter int OP_BIT     = OP_BIT_DEF,
  localparam int RID       = id_bits(NUM_REG)
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic [OP_BIT-1:0]         in_op,
  input  logic [RID-1:0]            in_src0,
  input  logic [RID-1:0]            in_src1,
  input  logic [RID-1:0]            in_dst,
  input  logic                      in_dst_vld,
  output logic                      rd_addr_vld,
  input  logic                      rd_addr_rdy,
  output logic [RID-1:0]            rd_addr0,
  output logic [RID-1:0]            rd_addr1,
  input  logic                      rd_data_vld,
  output logic                      rd_data_rdy,
  input  logic [REG_BIT-1:0]        rd_data0,
  input  logic [REG_BIT-1:0]        rd_data1,
  input  logic [NUM_W_PORT-1:0]     wb_vld,
  input  logic [NUM_W_PORT*RID-1:0] wb_addr,
  output logic                      ex_vld,
  input  logic                      ex_rdy,
  output logic [OP_BIT-1:0]         ex_op,
  output logic [RID-1:0]            ex_dst,
  output logic                      ex_dst_vld,
  output logic [REG_BIT-1:0]        ex_op0,
  output logic [REG_BIT-1:0]        ex_op1,
  output logic                      idle,
  output logic                      sb_err
);

  logic w_haz;
  logic w_any_busy;
  logic w_issue;
  logic w_rd_hs;

  logic [OP_BIT-1:0]  r_sb_op;
  logic [RID-1:0]     r_sb_dst;
  logic               r_sb_dv;
  logic               r_inflt;
  logic               r_ex_vld;
  logic [OP_BIT-1:0]  r_ex_op;
  logic [RID-1:0]     r_ex_dst;
  logic               r_ex_dv;
  logic [REG_BIT-1:0] r_ex_op0;
  logic [REG_BIT-1:0] r_ex_op1;

  reg_scoreboard #(
    .NUM_REG    (NUM_REG),
    .NUM_W_PORT (NUM_W_PORT),
    .RID        (RID)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set_vld  (w_issue & in_dst_vld),
    .i_set_addr (in_dst),
    .i_wb_vld   (wb_vld),
    .i_wb_addr  (wb_addr),
    .i_chk0     (in_src0),
    .i_chk1     (in_src1),
    .i_chk2     (in_dst),
    .i_chk2_vld (in_dst_vld),
    .o_hazard   (w_haz),
    .o_any_busy (w_any_busy),
    .o_sb_err   (sb_err)
  );

  assign rd_addr_vld = in_vld & ~w_haz;
  assign in_rdy      = rd_addr_rdy & ~w_haz;
  assign rd_addr0    = in_src0;
  assign rd_addr1    = in_src1;
  assign w_issue     = in_vld & in_rdy;

  assign rd_data_rdy = ~r_ex_vld | ex_rdy;
  assign w_rd_hs     = rd_data_vld & rd_data_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb_op  <= '0;
      r_sb_dst <= '0;
      r_sb_dv  <= 1'b0;
      r_inflt  <= 1'b0;
    end else begin
      if (w_issue) begin
        r_sb_op  <= in_op;
        r_sb_dst <= in_dst;
        r_sb_dv  <= in_dst_vld;
      end
      r_inflt <= w_issue | (r_inflt & ~w_rd_hs);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_vld <= 1'b0;
      r_ex_op  <= '0;
      r_ex_dst <= '0;
      r_ex_dv  <= 1'b0;
      r_ex_op0 <= '0;
      r_ex_op1 <= '0;
    end else if (w_rd_hs) begin
      r_ex_vld <= 1'b1;
      r_ex_op  <= r_sb_op;
      r_ex_dst <= r_sb_dst;
      r_ex_dv  <= r_sb_dv;
      r_ex_op0 <= rd_data0;
      r_ex_op1 <= rd_data1;
    end else if (ex_rdy) begin
      r_ex_vld <= 1'b0;
    end
  end

  assign ex_vld     = r_ex_vld;
  assign ex_op      = r_ex_op;
  assign ex_dst     = r_ex_dst;
  assign ex_dst_vld = r_ex_dv;
  assign ex_op0     = r_ex_op0;
  assign ex_op1     = r_ex_op1;
  assign idle       = ~w_any_busy & ~r_inflt & ~r_ex_vld;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a one-cycle
// register-file model on the read port.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_vld;
  logic        in_rdy;
  logic [3:0]  in_op;
  logic [2:0]  in_src0;
  logic [2:0]  in_src1;
  logic [2:0]  in_dst;
  logic        in_dst_vld;
  logic        rd_addr_vld;
  logic        rd_addr_rdy;
  logic [2:0]  rd_addr0;
  logic [2:0]  rd_addr1;
  logic        rd_data_vld;
  logic        rd_data_rdy;
  logic [15:0] rd_data0;
  logic [15:0] rd_data1;
  logic [1:0]  wb_vld;
  logic [5:0]  wb_addr;
  logic [15:0] wb_d0;
  logic [15:0] wb_d1;
  logic        ex_vld;
  logic        ex_rdy;
  logic [3:0]  ex_op;
  logic [2:0]  ex_dst;
  logic        ex_dst_vld;
  logic [15:0] ex_op0;
  logic [15:0] ex_op1;
  logic        idle;
  logic        sb_err;

  int chk_n  = 0;
  int pass_n = 0;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_vld      (in_vld),
    .in_rdy      (in_rdy),
    .in_op       (in_op),
    .in_src0     (in_src0),
    .in_src1     (in_src1),
    .in_dst      (in_dst),
    .in_dst_vld  (in_dst_vld),
    .rd_addr_vld (rd_addr_vld),
    .rd_addr_rdy (rd_addr_rdy),
    .rd_addr0    (rd_addr0),
    .rd_addr1    (rd_addr1),
    .rd_data_vld (rd_data_vld),
    .rd_data_rdy (rd_data_rdy),
    .rd_data0    (rd_data0),
    .rd_data1    (rd_data1),
    .wb_vld      (wb_vld),
    .wb_addr     (wb_addr),
    .ex_vld      (ex_vld),
    .ex_rdy      (ex_rdy),
    .ex_op       (ex_op),
    .ex_dst      (ex_dst),
    .ex_dst_vld  (ex_dst_vld),
    .ex_op0      (ex_op0),
    .ex_op1      (ex_op1),
    .idle        (idle),
    .sb_err      (sb_err)
  );

  logic [15:0] rf [8] = '{16'h0000, 16'h0011, 16'h0022, 16'h0033,
                          16'h0044, 16'h0055, 16'h0066, 16'h0077};
  logic        m_dvld;
  logic [15:0] m_d0;
  logic [15:0] m_d1;

  always @(posedge clk) begin
    if (wb_vld[0] && wb_addr[2:0] != 3'd0) rf[wb_addr[2:0]] <= wb_d0;
    if (wb_vld[1] && wb_addr[5:3] != 3'd0) rf[wb_addr[5:3]] <= wb_d1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dvld <= 1'b0;
      m_d0   <= '0;
      m_d1   <= '0;
    end else if (rd_addr_vld && rd_addr_rdy) begin
      m_dvld <= 1'b1;
      m_d0   <= rf[rd_addr0];
      m_d1   <= rf[rd_addr1];
    end else if (rd_data_rdy) begin
      m_dvld <= 1'b0;
    end
  end

  assign rd_addr_rdy = !(m_dvld && !rd_data_rdy);
  assign rd_data_vld = m_dvld;
  assign rd_data0    = m_d0;
  assign rd_data1    = m_d1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_vld = 1'b0; in_op = '0;
    in_src0 = '0; in_src1 = '0; in_dst = '0;
    in_dst_vld = 1'b0; wb_vld = '0; wb_addr = '0;
    wb_d0 = '0; wb_d1 = '0; ex_rdy = 1'b1;
    #3;
    chk_n++; if (ex_vld !== 1'b0) $display("FAIL rst_ex_vld got %b want 0", ex_vld); else pass_n++;
    chk_n++; if (idle !== 1'b1) $display("FAIL rst_idle got %b want 1", idle); else pass_n++;
    chk_n++; if (sb_err !== 1'b0) $display("FAIL rst_sb_err got %b want 0", sb_err); else pass_n++;
    chk_n++; if (ex_op0 !== 16'h0) $display("FAIL rst_ex_op0 got %h want 0", ex_op0); else pass_n++;
    chk_n++; if (ex_dst !== 3'd0) $display("FAIL rst_ex_dst got %0d want 0", ex_dst); else pass_n++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    in_vld = 1'b1; in_op = 4'h5; in_src0 = 3'd1;
    in_src1 = 3'd2; in_dst = 3'd3; in_dst_vld = 1'b1;
    #1;
    chk_n++; if (in_rdy !== 1'b1) $display("FAIL basic_in_rdy got %b want 1", in_rdy); else pass_n++;
    chk_n++; if (rd_addr1 !== 3'd2) $display("FAIL basic_addr1 got %0d want 2", rd_addr1); else pass_n++;
    tick();
    in_vld = 1'b0;
    chk_n++; if (ex_vld !== 1'b0) $display("FAIL basic_t1_vld got %b want 0", ex_vld); else pass_n++;
    chk_n++; if (idle !== 1'b0) $display("FAIL basic_idle got %b want 0", idle); else pass_n++;
    tick();
    chk_n++; if (ex_vld !== 1'b1) $display("FAIL basic_t2_vld got %b want 1", ex_vld); else pass_n++;
    chk_n++; if (ex_op0 !== 16'h0011) $display("FAIL basic_op0 got %h want 0011", ex_op0); else pass_n++;
    chk_n++; if (ex_op1 !== 16'h0022) $display("FAIL basic_op1 got %h want 0022", ex_op1); else pass_n++;
    chk_n++; if (ex_dst !== 3'd3) $display("FAIL basic_dst got %0d want 3", ex_dst); else pass_n++;
    chk_n++; if (ex_op !== 4'h5) $display("FAIL basic_op got %h want 5", ex_op); else pass_n++;
    chk_n++; if (ex_dst_vld !== 1'b1) $display("FAIL basic_dv got %b want 1", ex_dst_vld); else pass_n++;
    tick();
    chk_n++; if (ex_vld !== 1'b0) $display("FAIL basic_t3_vld got %b want 0", ex_vld); else pass_n++;
    chk_n++; if (idle !== 1'b0) $display("FAIL basic_busy3 got %b want 0", idle); else pass_n++;
  endtask

  task automatic test_dependent;
    in_vld = 1'b1; in_op = 4'h6; in_src0 = 3'd3;
    in_src1 = 3'd0; in_dst = 3'd4; in_dst_vld = 1'b1;
    #1;
    chk_n++; if (in_rdy !== 1'b0) $display("FAIL dep_stall got %b want 0", in_rdy); else pass_n++;
    chk_n++; if (rd_addr_vld !== 1'b0) $display("FAIL dep_req got %b want 0", rd_addr_vld); else pass_n++;
    tick(); tick();
    chk_n++; if (in_rdy !== 1'b0) $display("FAIL dep_hold got %b want 0", in_rdy); else pass_n++;
    wb_vld = 2'b10; wb_addr = {3'd3, 3'd0}; wb_d1 = 16'h00AB;
    #1;
    chk_n++; if (in_rdy !== 1'b0) $display("FAIL dep_nobypass got %b want 0", in_rdy); else pass_n++;
    tick();
    wb_vld = 2'b00;
    #1;
    chk_n++; if (in_rdy !== 1'b1) $display("FAIL dep_release got %b want 1", in_rdy); else pass_n++;
    tick();
    in_vld = 1'b0;
    tick();
    chk_n++; if (ex_op0 !== 16'h00AB) $display("FAIL dep_op0 got %h want 00ab", ex_op0); else pass_n++;
    chk_n++; if (ex_dst !== 3'd4) $display("FAIL dep_dst got %0d want 4", ex_dst); else pass_n++;
    tick();
    wb_vld = 2'b01; wb_addr = {3'd0, 3'd4}; wb_d0 = 16'h0044;
    tick();
    wb_vld = 2'b00;
    chk_n++; if (idle !== 1'b1) $display("FAIL dep_idle got %b want 1", idle); else pass_n++;
    chk_n++; if (sb_err !== 1'b0) $display("FAIL dep_sb_err got %b want 0", sb_err); else pass_n++;
  endtask

  task automatic test_backpressure;
    ex_rdy = 1'b0; in_vld = 1'b1; in_op = 4'h1;
    in_src0 = 3'd1; in_src1 = 3'd2; in_dst = 3'd0; in_dst_vld = 1'b0;
    #1;
    chk_n++; if (in_rdy !== 1'b1) $display("FAIL bp_i1_rdy got %b want 1", in_rdy); else pass_n++;
    tick();
    in_op = 4'h2; in_src0 = 3'd2; in_src1 = 3'd1;
    #1;
    chk_n++; if (in_rdy !== 1'b1) $display("FAIL bp_i2_rdy got %b want 1", in_rdy); else pass_n++;
    tick();
    in_op = 4'h3; in_src0 = 3'd5; in_src1 = 3'd6;
    #1;
    chk_n++; if (ex_op !== 4'h1) $display("FAIL bp_first_op got %h want 1", ex_op); else pass_n++;
    chk_n++; if (rd_data_rdy !== 1'b0) $display("FAIL bp_data_rdy got %b want 0", rd_data_rdy); else pass_n++;
    chk_n++; if (in_rdy !== 1'b0) $display("FAIL bp_i3_block got %b want 0", in_rdy); else pass_n++;
    tick(); tick();
    chk_n++; if (ex_op0 !== 16'h0011) $display("FAIL bp_hold_op0 got %h want 0011", ex_op0); else pass_n++;
    chk_n++; if (ex_op1 !== 16'h0022) $display("FAIL bp_hold_op1 got %h want 0022", ex_op1); else pass_n++;
    chk_n++; if (in_rdy !== 1'b0) $display("FAIL bp_hold_rdy got %b want 0", in_rdy); else pass_n++;
    ex_rdy = 1'b1;
    #1;
    chk_n++; if (in_rdy !== 1'b1) $display("FAIL bp_unblock got %b want 1", in_rdy); else pass_n++;
    tick();
    in_vld = 1'b0;
    chk_n++; if (ex_op !== 4'h2) $display("FAIL bp_second_op got %h want 2", ex_op); else pass_n++;
    chk_n++; if (ex_op0 !== 16'h0022) $display("FAIL bp_second_op0 got %h want 0022", ex_op0); else pass_n++;
    tick();
    chk_n++; if (ex_op !== 4'h3) $display("FAIL bp_third_op got %h want 3", ex_op); else pass_n++;
    chk_n++; if (ex_op1 !== 16'h0066) $display("FAIL bp_third_op1 got %h want 0066", ex_op1); else pass_n++;
    tick();
    chk_n++; if (idle !== 1'b1) $display("FAIL bp_drain got %b want 1", idle); else pass_n++;
  endtask

  task automatic test_reg0;
    ex_rdy = 1'b1; in_vld = 1'b1; in_op = 4'h7;
    in_src0 = 3'd0; in_src1 = 3'd1; in_dst = 3'd0; in_dst_vld = 1'b1;
    #1;
    chk_n++; if (in_rdy !== 1'b1) $display("FAIL r0_first got %b want 1", in_rdy); else pass_n++;
    tick();
    chk_n++; if (in_rdy !== 1'b1) $display("FAIL r0_second got %b want 1", in_rdy); else pass_n++;
    tick();
    in_vld = 1'b0;
    chk_n++; if (ex_op0 !== 16'h0000) $display("FAIL r0_op0 got %h want 0000", ex_op0); else pass_n++;
    tick();
    chk_n++; if (ex_vld !== 1'b1) $display("FAIL r0_b2b got %b want 1", ex_vld); else pass_n++;
    tick();
    chk_n++; if (idle !== 1'b1) $display("FAIL r0_idle got %b want 1", idle); else pass_n++;
    wb_vld = 2'b01; wb_addr = 6'd0; wb_d0 = 16'hFFFF;
    tick();
    wb_vld = 2'b00;
    chk_n++; if (sb_err !== 1'b0) $display("FAIL r0_wb_err got %b want 0", sb_err); else pass_n++;
  endtask

  task automatic test_dual_wb;
    in_vld = 1'b1; in_op = 4'h8; in_src0 = 3'd0;
    in_src1 = 3'd0; in_dst = 3'd2; in_dst_vld = 1'b1;
    tick();
    in_dst = 3'd5;
    #1;
    chk_n++; if (in_rdy !== 1'b1) $display("FAIL dual_issue got %b want 1", in_rdy); else pass_n++;
    tick();
    in_vld = 1'b0;
    tick(); tick();
    in_vld = 1'b1; in_src0 = 3'd5; in_dst_vld = 1'b0;
    #1;
    chk_n++; if (in_rdy !== 1'b0) $display("FAIL dual_raw got %b want 0", in_rdy); else pass_n++;
    in_vld = 1'b0;
    wb_vld = 2'b11; wb_addr = {3'd5, 3'd2};
    wb_d0 = 16'h0202; wb_d1 = 16'h0505;
    tick();
    wb_vld = 2'b00;
    chk_n++; if (idle !== 1'b1) $display("FAIL dual_clear got %b want 1", idle); else pass_n++;
    chk_n++; if (sb_err !== 1'b0) $display("FAIL dual_no_err got %b want 0", sb_err); else pass_n++;
    wb_vld = 2'b01; wb_addr = {3'd0, 3'd5};
    tick();
    wb_vld = 2'b00;
    chk_n++; if (sb_err !== 1'b1) $display("FAIL dual_err got %b want 1", sb_err); else pass_n++;
    tick(); tick();
    chk_n++; if (sb_err !== 1'b1) $display("FAIL dual_sticky got %b want 1", sb_err); else pass_n++;
  endtask

  task automatic test_reset_inflight;
    in_vld = 1'b1; in_op = 4'h9; in_src0 = 3'd1;
    in_src1 = 3'd1; in_dst = 3'd4; in_dst_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    chk_n++; if (idle !== 1'b0) $display("FAIL rif_busy got %b want 0", idle); else pass_n++;
    rst_n = 1'b0;
    #1;
    chk_n++; if (idle !== 1'b1) $display("FAIL rif_idle got %b want 1", idle); else pass_n++;
    chk_n++; if (ex_vld !== 1'b0) $display("FAIL rif_ex_vld got %b want 0", ex_vld); else pass_n++;
    chk_n++; if (sb_err !== 1'b0) $display("FAIL rif_sb_err got %b want 0", sb_err); else pass_n++;
    tick();
    rst_n = 1'b1;
    in_vld = 1'b1; in_op = 4'hA; in_src0 = 3'd4;
    in_src1 = 3'd2; in_dst = 3'd6; in_dst_vld = 1'b0;
    #1;
    chk_n++; if (in_rdy !== 1'b1) $display("FAIL rif_nostall got %b want 1", in_rdy); else pass_n++;
    tick();
    in_vld = 1'b0;
    tick();
    chk_n++; if (ex_op0 !== 16'h0044) $display("FAIL rif_op0 got %h want 0044", ex_op0); else pass_n++;
    chk_n++; if (ex_op1 !== 16'h0202) $display("FAIL rif_op1 got %h want 0202", ex_op1); else pass_n++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dependent();
    test_backpressure();
    test_reg0();
    test_dual_wb();
    test_reset_inflight();
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule
